// File: rtl/centroid_div_sched.sv
// Frame scheduler that shares one sequential divider between the X and Y centroid quotients.
// It latches the moments on eof, runs m10/m00 and then m01/m00, and publishes both results with a valid strobe.
module centroid_div_sched #(
  parameter int TIMEOUT = 64,
  parameter int OVR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eof,
  input  logic [19:0]      m00,
  input  logic [31:0]      m10,
  input  logic [31:0]      m01,
  output logic             div_start,
  output logic [31:0]      div_dividend,
  output logic [19:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic             div_qv,
  output logic [31:0]      x,
  output logic [31:0]      y,
  output logic             valid,
  output logic             empty,
  output logic             err,
  output logic             busy,
  output logic [OVR_W-1:0] ovr_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START_X = 3'd1;
  localparam logic [2:0] S_WAIT_X  = 3'd2;
  localparam logic [2:0] S_START_Y = 3'd3;
  localparam logic [2:0] S_WAIT_Y  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [19:0]      lat_m00_q, lat_m00_d;
  logic [31:0]      lat_m10_q, lat_m10_d;
  logic [31:0]      lat_m01_q, lat_m01_d;
  logic [31:0]      x_tmp_q, x_tmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path through the case leaves one unassigned and infers a latch.
    state_d   = state_q;
    lat_m00_d = lat_m00_q;
    lat_m10_d = lat_m10_q;
    lat_m01_d = lat_m01_q;
    x_tmp_d   = x_tmp_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    empty_d   = empty_q;
    err_d     = err_q;
    ovr_d     = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (eof) begin
          lat_m00_d = m00;
          lat_m10_d = m10;
          lat_m01_d = m01;
          if (m00 == 20'd0) begin
            // The result registers are written here so that they are already visible in the DONE cycle.
            state_d = S_DONE;
            x_d     = '0;
            y_d     = '0;
            empty_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = S_START_X;
          end
        end
      end
      S_START_X: begin
        state_d = S_WAIT_X;
        cnt_d   = '0;
      end
      S_WAIT_X: begin
        if (div_qv) begin
          x_tmp_d = div_quotient;
          state_d = S_START_Y;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          empty_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START_Y: begin
        state_d = S_WAIT_Y;
        cnt_d   = '0;
      end
      S_WAIT_Y: begin
        if (div_qv) begin
          state_d = S_DONE;
          x_d     = x_tmp_q;
          y_d     = div_quotient;
          empty_d = 1'b0;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          empty_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A frame that arrives while busy, including in DONE, is dropped and counted.
    if (eof && state_q != S_IDLE && ovr_q != {OVR_W{1'b1}})
      ovr_d = ovr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so that every flop samples the pre-edge values of the others.
    if (rst) begin
      state_q   <= S_IDLE;
      lat_m00_q <= '0;
      lat_m10_q <= '0;
      lat_m01_q <= '0;
      x_tmp_q   <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      empty_q   <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_m00_q <= lat_m00_d;
      lat_m10_q <= lat_m10_d;
      lat_m01_q <= lat_m01_d;
      x_tmp_q   <= x_tmp_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign div_start    = (state_q == S_START_X) || (state_q == S_START_Y);
  assign div_dividend = (state_q == S_START_X || state_q == S_WAIT_X) ? lat_m10_q : lat_m01_q;
  assign div_divisor  = lat_m00_q;
  assign x            = x_q;
  assign y            = y_q;
  assign valid        = (state_q == S_DONE);
  assign empty        = empty_q;
  assign err          = err_q;
  assign busy         = (state_q != S_IDLE);
  assign ovr_cnt      = ovr_q;

endmodule

// File: tb/tb_centroid_div_sched.sv
// Bench for centroid_div_sched: a behavioural divider with programmable latency/hang,
// and directed plus random frames that are checked against centroid arithmetic done in the bench.
module tb_centroid_div_sched;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic        eof;
  logic [19:0] m00;
  logic [31:0] m10, m01;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [19:0] div_divisor;
  logic [31:0] div_quotient;
  logic        div_qv;
  logic [31:0] x, y;
  logic        valid, empty, err, busy;
  logic [7:0]  ovr_cnt;

  // Second instance with a 2-bit overrun counter; it sees identical stimulus.
  logic        s2_start;
  logic [31:0] s2_dividend;
  logic [19:0] s2_divisor;
  logic [31:0] s2_x, s2_y;
  logic        s2_valid, s2_empty, s2_err, s2_busy;
  logic [1:0]  ovr2;

  centroid_div_sched #(.TIMEOUT(TIMEOUT), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .eof(eof), .m00(m00), .m10(m10), .m01(m01),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_qv(div_qv),
    .x(x), .y(y), .valid(valid), .empty(empty), .err(err), .busy(busy), .ovr_cnt(ovr_cnt)
  );

  centroid_div_sched #(.TIMEOUT(TIMEOUT), .OVR_W(2)) dut_ovr (
    .clk(clk), .rst(rst), .eof(eof), .m00(m00), .m10(m10), .m01(m01),
    .div_start(s2_start), .div_dividend(s2_dividend), .div_divisor(s2_divisor),
    .div_quotient(div_quotient), .div_qv(div_qv),
    .x(s2_x), .y(s2_y), .valid(s2_valid), .empty(s2_empty), .err(s2_err), .busy(s2_busy),
    .ovr_cnt(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Divider model and output monitor share one process so that sampling precedes driving.
  int          m_lat  = 35;
  bit          m_hang = 1'b0;
  bit          m_busy = 1'b0;
  int          m_cd   = 0;
  logic [31:0] m_dvd;
  logic [19:0] m_dvs;
  bit          chk_stab = 1'b1;
  int          stab_err = 0;
  int          valid_cnt = 0;
  int          valid_cyc = 0;
  int          qv_cyc = 0;
  logic [31:0] v_x, v_y;
  logic        v_empty, v_err;
  logic [31:0] st_dvd[$];
  int          st_cyc[$];

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      v_x = x; v_y = y; v_empty = empty; v_err = err;
    end
    if (chk_stab && m_busy && (div_dividend !== m_dvd || div_divisor !== m_dvs))
      stab_err++;
    div_qv = 1'b0;
    if (m_busy) begin
      if (m_cd == 0) begin
        div_qv       = 1'b1;
        div_quotient = m_dvd / 32'(m_dvs);
        m_busy       = 1'b0;
        qv_cyc       = cyc;
      end else begin
        m_cd--;
      end
    end
    if (div_start) begin
      st_dvd.push_back(div_dividend);
      st_cyc.push_back(cyc);
      if (!(m_hang && st_dvd.size() == 2)) begin
        m_busy = 1'b1;
        m_dvd  = div_dividend;
        m_dvs  = div_divisor;
        m_cd   = m_lat - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] prev_x = '0;
  logic [31:0] prev_y = '0;

  // One frame: eof with the given moments, scrambled inputs afterwards, optional dropped eofs.
  task automatic do_frame(input string tag, input logic [19:0] a, input logic [31:0] b,
                          input logic [31:0] c, input int lat, input bit hang, input int drops);
    int v0, n, eof_cyc;
    logic [31:0] ex, ey;
    logic ee, er;
    m_lat = lat;
    m_hang = hang;
    st_dvd.delete();
    st_cyc.delete();
    v0 = valid_cnt;
    m00 = a; m10 = b; m01 = c; eof = 1'b1;
    eof_cyc = cyc;
    step();
    eof = 1'b0;
    n = 0;
    while (valid_cnt == v0 && n < 400) begin
      m00 = 20'($urandom); m10 = $urandom; m01 = $urandom;
      eof = (drops > 0 && n >= 2 && n < 2 + 2 * drops && n % 2 == 0);
      step();
      n++;
    end
    eof = 1'b0;
    check({tag, "_valid_seen"}, 64'(n < 400), 64'd1);
    check({tag, "_one_valid"}, 64'(valid_cnt - v0), 64'd1);

    if (a == 20'd0) begin
      ex = '0; ey = '0; ee = 1'b1; er = 1'b0;
    end else if (hang) begin
      ex = prev_x; ey = prev_y; ee = 1'b0; er = 1'b1;
    end else begin
      ex = b / 32'(a); ey = c / 32'(a); ee = 1'b0; er = 1'b0;
    end
    check({tag, "_x"}, 64'(v_x), 64'(ex));
    check({tag, "_y"}, 64'(v_y), 64'(ey));
    check({tag, "_empty"}, 64'(v_empty), 64'(ee));
    check({tag, "_err"}, 64'(v_err), 64'(er));

    if (a == 20'd0) begin
      check({tag, "_no_start"}, 64'(st_dvd.size()), 64'd0);
      check({tag, "_valid_lat"}, 64'(valid_cyc), 64'(eof_cyc + 1));
    end else begin
      check({tag, "_starts"}, 64'(st_dvd.size()), 64'd2);
      if (st_dvd.size() == 2) begin
        check({tag, "_dvd_x"}, 64'(st_dvd[0]), 64'(b));
        check({tag, "_dvd_y"}, 64'(st_dvd[1]), 64'(c));
        check({tag, "_start_lat"}, 64'(st_cyc[0]), 64'(eof_cyc + 1));
        if (hang)
          check({tag, "_timeout_lat"}, 64'(valid_cyc), 64'(st_cyc[1] + TIMEOUT + 1));
        else
          check({tag, "_valid_lat"}, 64'(valid_cyc), 64'(qv_cyc + 1));
      end
    end
    prev_x = ex;
    prev_y = ey;
    step();
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_x_held"}, 64'(x), 64'(ex));
  endtask

  initial begin
    int v0, n, ovr_exp;
    logic [19:0] ra;
    rst = 1'b1; eof = 1'b0; m00 = '0; m10 = '0; m01 = '0;
    div_qv = 1'b0; div_quotient = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_x", 64'(x), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovr", 64'(ovr_cnt), 64'd0);
    check("rst_start", 64'(div_start), 64'd0);

    do_frame("normal", 20'd4, 32'd40, 32'd100, 35, 1'b0, 0);
    check("normal_x_10", 64'(x), 64'd10);
    check("normal_y_25", 64'(y), 64'd25);

    do_frame("empty", 20'd0, 32'd77, 32'd99, 35, 1'b0, 0);
    do_frame("pre_hang", 20'd7, 32'd1000, 32'd2001, 12, 1'b0, 0);
    do_frame("hang", 20'd3, 32'd30, 32'd60, 12, 1'b1, 0);
    check("hang_x_prev", 64'(x), 64'd142);
    check("hang_y_prev", 64'(y), 64'd285);

    do_frame("ovr3", 20'd5, 32'd500, 32'd255, 35, 1'b0, 3);
    check("ovr3_cnt", 64'(ovr_cnt), 64'd3);
    check("ovr3_cnt_w2", 64'(ovr2), 64'd3);
    do_frame("ovr5", 20'd9, 32'd900, 32'd91, 35, 1'b0, 2);
    check("ovr5_cnt", 64'(ovr_cnt), 64'd5);
    check("ovr5_sat_w2", 64'(ovr2), 64'd3);

    // eof during the DONE cycle is dropped and counted.
    m_lat = 20; m_hang = 1'b0;
    st_dvd.delete(); st_cyc.delete();
    v0 = valid_cnt;
    m00 = 20'd6; m10 = 32'd600; m01 = 32'd66; eof = 1'b1;
    step();
    eof = 1'b0;
    n = 0;
    while (valid_cnt == v0 && n < 200) begin
      step();
      n++;
    end
    check("done_eof_valid_seen", 64'(n < 200), 64'd1);
    m00 = 20'd1; m10 = 32'd5; m01 = 32'd5; eof = 1'b1;
    step();
    eof = 1'b0;
    repeat (5) step();
    check("done_eof_ovr", 64'(ovr_cnt), 64'd6);
    check("done_eof_no_start", 64'(st_dvd.size()), 64'd2);
    check("done_eof_one_valid", 64'(valid_cnt - v0), 64'd1);
    check("done_eof_idle", 64'(busy), 64'd0);
    check("done_eof_x", 64'(x), 64'd100);
    prev_x = 32'd100; prev_y = 32'd11;

    // qv on the last counted WAIT cycle still wins over the timeout.
    do_frame("qv_at_timeout", 20'd8, 32'd800, 32'd88, TIMEOUT, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 20'd0;
        1:       ra = 20'($urandom_range(1, 1000));
        default: ra = 20'($urandom);
      endcase
      if (ra == 20'd0 && $urandom_range(0, 1) == 1) ra = 20'd1;
      do_frame($sformatf("rnd%0d", i), ra, $urandom, $urandom, $urandom_range(1, 40), 1'b0, 0);
    end
    ovr_exp = 6;
    check("rnd_ovr_unchanged", 64'(ovr_cnt), 64'(ovr_exp));

    // Reset during WAIT_Y; the divider still answers afterwards and must be ignored.
    m_lat = 30; m_hang = 1'b0;
    st_dvd.delete(); st_cyc.delete();
    m00 = 20'd2; m10 = 32'd20; m01 = 32'd40; eof = 1'b1;
    step();
    eof = 1'b0;
    n = 0;
    while (st_dvd.size() < 2 && n < 200) begin
      step();
      n++;
    end
    check("rstmid_reached_wait_y", 64'(st_dvd.size()), 64'd2);
    repeat (4) step();
    chk_stab = 1'b0;
    v0 = valid_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_ovr", 64'(ovr_cnt), 64'd0);
    n = 0;
    while (m_busy && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    check("rstmid_late_qv_seen", 64'(n < 200), 64'd1);
    check("rstmid_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("rstmid_x", 64'(x), 64'd0);
    check("rstmid_y", 64'(y), 64'd0);
    check("rstmid_empty", 64'(empty), 64'd0);
    check("rstmid_err", 64'(err), 64'd0);
    check("rstmid_busy_after", 64'(busy), 64'd0);
    chk_stab = 1'b1;
    prev_x = '0; prev_y = '0;

    do_frame("after_rst", 20'd3, 32'd31, 32'd62, 17, 1'b0, 0);
    check("operand_stability", 64'(stab_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/centroid_div_sched.md
# centroid_div_sched

Frame-level scheduler that shares one sequential 32/20 divider between the X and Y centroid quotients. The divider is the same divider type already used for centroid computation. On each end-of-frame strobe it latches the moment sums, runs X = m10/m00 and then Y = m01/m00 through the single divider, and publishes both results together with a one-cycle valid strobe. It sits between the moment accumulator and the downstream marker/overlay logic. It also handles empty frames, divider hangs and frames that arrive too fast.

## Interface
- TIMEOUT, 64, max cycles to wait for div_qv per division before aborting (must be ≥ divider latency + 1).
- OVR_W, 8, width of saturating overrun counter.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- eof  in  1  one-cycle end-of-frame pulse (vsync rising edge).
- m00  in  20  pixel count of mask, sampled on eof.
- m10  in  32  sum of x positions, sampled on eof.
- m01  in  32  sum of y positions, sampled on eof.
- div_start  out  1  one-cycle start pulse to shared divider.
- div_dividend  out  32  dividend to divider.
- div_divisor  out  20  divisor to divider.
- div_quotient  in  32  divider result.
- div_qv  in  1  divider quotient-valid pulse.
- x  out  32  published X centroid.
- y  out  32  published Y centroid.
- valid  out  1  one-cycle pulse when x/y/empty/err are updated.
- empty  out  1  last frame had m00 = 0.
- err  out  1  last frame aborted on timeout.
- busy  out  1  high in any state other than IDLE.
- ovr_cnt  out  OVR_W  count of eof pulses dropped while busy, saturating.

## Operation
- States: IDLE, START_X, WAIT_X, START_Y, WAIT_Y, DONE.
- IDLE + eof: latch m00/m10/m01 into lat_* registers.
  - m00 = 0 → DONE with empty flag pending. Divider is not started.
  - m00 ≠ 0 → START_X.
- START_X: div_start = 1, dividend = lat_m10. Go to WAIT_X.
- WAIT_X: div_qv = 1 → capture div_quotient into x_tmp, go to START_Y. Timeout counter reaching TIMEOUT → DONE with err pending.
- START_Y / WAIT_Y: same sequence using lat_m01, capturing into y_tmp.
- DONE, one cycle:
  - Normal: x ← x_tmp, y ← y_tmp, empty ← 0, err ← 0.
  - Empty frame: x ← 0, y ← 0, empty ← 1, err ← 0.
  - Timeout: x and y hold their previous values, err ← 1, empty ← 0.
  - All cases: valid = 1, then go to IDLE.
- Divider operands:
  - div_divisor = lat_m00 at all times.
  - div_dividend = lat_m10 in START_X/WAIT_X; lat_m01 otherwise.
  - Operands are stable from the start pulse until qv.
- div_qv outside WAIT_X/WAIT_Y is ignored.
- eof while busy (any state ≠ IDLE, including DONE): the frame is dropped, latches are untouched, ovr_cnt += 1 and saturates at 2^OVR_W−1.
- The timeout counter clears on entry to each WAIT state.
- No arithmetic is done locally. The quotient is passed through unchanged, and the divider's truncation applies.

## Timing
- Reset values:
  - Outputs x = 0, y = 0, valid = 0, empty = 0, err = 0, busy = 0, ovr_cnt = 0, div_start = 0.
  - State returns to IDLE and lat_*/x_tmp/y_tmp are cleared.
- Reset mid-operation aborts immediately. A div_qv arriving later is ignored.
- Normal frame, with eof at cycle T:
  - START_X at T+1 (div_start high), WAIT_X from T+2.
  - qv_x at cycle Q → START_Y at Q+1.
  - qv_y at cycle R → DONE at R+1, so valid and the new x/y are visible at R+1.
  - busy falls at R+2.
- Empty frame: valid at T+1.
- Timeout: reached after TIMEOUT cycles in a WAIT state without qv; valid with err follows on the next cycle.
- div_qv in the same cycle the counter hits TIMEOUT: qv wins.
- eof and rst in the same cycle: rst wins.
- eof in the same cycle DONE returns to IDLE: the frame is dropped and counted.

## Test plan
- Normal frame: m00 = 4, m10 = 40, m01 = 100, divider model with 35-cycle latency → exactly two div_start pulses, the first with dividend 40 and the second with 100. One valid pulse gives x = 10, y = 25, empty = 0, err = 0.
- Empty frame: m00 = 0 → no div_start, valid at T+1 with x = 0, y = 0, empty = 1.
- Hang: model never asserts qv on the Y division, TIMEOUT = 64 → valid with err = 1, x/y keep the previous frame's values, state back in IDLE.
- Overrun: three eof pulses while busy → ovr_cnt = 3. With OVR_W = 2, 5 drops → ovr_cnt = 3 (saturated). The result matches the first frame only.
- Operand stability: change m10/m01/m00 inputs every cycle after eof → div_dividend/div_divisor stay constant until qv, and results use the values sampled at eof.
- Reset mid-WAIT_Y, then a late qv → no valid, all outputs at reset values. The next frame completes normally.
